// File: rtl/radix_updown_counter.sv
// -----------------------------------------------------------------------------
// radix_updown_counter
//
// Multi-digit base-RADIX up/down counter. NDIGITS digits of DW bits each are
// packed into one registered bus, digit 0 least significant. Digits cascade:
// counting up, a digit at RADIX-1 rolls to 0 and carries into the next digit.
// Counting down, a digit at 0 rolls to RADIX-1 and borrows from the next digit.
// The whole carry/borrow chain settles in one cycle.
//
// Update priority on each rising clk edge: clr > load > en.
//   clr  : every digit goes to 0 (direct=1) or RADIX-1 (direct=0).
//   load : every digit takes its load_val field, clamped to RADIX-1.
//   en   : one step in the direction given by direct.
//
// Optional build macro:
//   SATURATE_EN - the counter holds at all-(RADIX-1) going up and at all-0
//                 going down instead of wrapping; wrap is then always 0.
//
// Parameters:
//   RADIX   - base of each digit, 2..256
//   NDIGITS - number of cascaded digits, 1..16
//   DW      - bits per digit, derived, not overridable
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (count=0, wrap=0)
//   en       in   count enable
//   direct   in   1 = count up, 0 = count down
//   clr      in   synchronous direction-aware clear
//   load     in   synchronous parallel load
//   load_val in   load value, digit i at [i*DW +: DW]
//   count    out  registered counter value, same packing as load_val
//   tc       out  combinational terminal count: en and count at the limit
//                 for the current direction
//   wrap     out  registered one-cycle pulse after a wrapping step
// -----------------------------------------------------------------------------
module radix_updown_counter #(
  parameter int  RADIX   = 3,
  parameter int  NDIGITS = 4,
  localparam int DW      = (RADIX > 2) ? $clog2(RADIX) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    direct,
  input  logic                    clr,
  input  logic                    load,
  input  logic [NDIGITS*DW-1:0]   load_val,
  output logic [NDIGITS*DW-1:0]   count,
  output logic                    tc,
  output logic                    wrap
);

  localparam logic [DW-1:0] MAX_DIGIT = DW'(RADIX - 1);

  logic [NDIGITS*DW-1:0] step_val;    // count after one step in direction direct
  logic [NDIGITS*DW-1:0] load_clamp;  // load_val with each field clamped
  logic [NDIGITS*DW-1:0] clr_val;     // direction-dependent clear value
  logic                  ripple;      // carry (up) or borrow (down) into digit i
  logic                  all_max;
  logic                  all_zero;

  // Ripple-carry step across all digits plus limit detection.
  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    step_val = count;
    ripple   = 1'b1;
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      all_max  = all_max  & (count[i*DW +: DW] == MAX_DIGIT);
      all_zero = all_zero & (count[i*DW +: DW] == '0);
      if (ripple) begin
        if (direct) begin
          step_val[i*DW +: DW] = (count[i*DW +: DW] == MAX_DIGIT) ?
                                 '0 : count[i*DW +: DW] + 1'b1;
          ripple = (count[i*DW +: DW] == MAX_DIGIT);
        end else begin
          step_val[i*DW +: DW] = (count[i*DW +: DW] == '0) ?
                                 MAX_DIGIT : count[i*DW +: DW] - 1'b1;
          ripple = (count[i*DW +: DW] == '0);
        end
      end
    end
  end

  // A limit-reached step is exactly a step whose ripple leaves the top digit,
  // so tc doubles as the "this step wraps" indicator.
  assign tc = en & (direct ? all_max : all_zero);

  // Field clamp: compare one bit wider so RADIX itself is representable when
  // RADIX is a power of two (e.g. 256 with DW=8, where nothing clamps).
  always_comb begin
    load_clamp = load_val;
    for (int i = 0; i < NDIGITS; i++) begin
      if ({1'b0, load_val[i*DW +: DW]} >= (DW+1)'(RADIX))
        load_clamp[i*DW +: DW] = MAX_DIGIT;
    end
  end

  assign clr_val = direct ? '0 : {NDIGITS{MAX_DIGIT}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= clr_val;
      end else if (load) begin
        count <= load_clamp;
      end else if (en) begin
`ifdef SATURATE_EN
        if (!tc) count <= step_val;
`else
        count <= step_val;
        wrap  <= tc;
`endif
      end
    end
  end

endmodule

// File: doc/radix_updown_counter.md
Name: radix_updown_counter

Overview:
- Parametrised multi-digit base-RADIX up/down counter; generalises the team's mod-3 (ternary) counter to any radix and digit count.
- Adds cascaded digits, synchronous direction-aware clear, parallel load, terminal-count and wrap flags.
- Used as a sequencer/index generator for multi-valued logic datapaths; count is one registered packed bus.

Parameters:
- RADIX, 3, base of each digit; legal range 2..256.
- NDIGITS, 4, number of cascaded digits; legal range 1..16.
- DW, derived localparam = max(1, $clog2(RADIX)), bits per digit; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; one step per clk while high.
- direct  in  1  1 = count up, 0 = count down; sampled every edge.
- clr  in  1  synchronous clear, direction-aware.
- load  in  1  synchronous parallel load.
- load_val  in  NDIGITS*DW  load value; digit i at [i*DW +: DW], digit 0 least significant.
- count  out  NDIGITS*DW  registered counter value, same packing.
- tc  out  1  combinational terminal count.
- wrap  out  1  registered one-cycle wrap pulse.

Behaviour:
- Reset: rst high clears count and wrap to 0 immediately, with no clock required. Reset has priority over everything.
- Update priority on each rising edge: clr > load > en. With none active, count holds.
- clr: every digit loads 0 if direct=1, or RADIX-1 if direct=0. Matches the ternary counter's direction-dependent start value. wrap=0.
- load: each digit loads its load_val field. A field >= RADIX is clamped to RADIX-1. wrap=0.
- Count up (en=1, direct=1):
  - Digit 0 increments.
  - A digit equal to RADIX-1 rolls to 0 and carries into the next digit.
  - Carry out of the top digit wraps the whole counter to all-zero.
- Count down (en=1, direct=0):
  - Digit 0 decrements.
  - A digit equal to 0 rolls to RADIX-1 and borrows from the next digit.
  - Borrow out of the top digit wraps the whole counter to all-(RADIX-1).
- All digit arithmetic is modulo RADIX. The carry/borrow ripple resolves within one cycle, so each step has 1-cycle latency.
- tc = en & (direct ? all digits == RADIX-1 : all digits == 0). Purely combinational from the current count, en and direct.
- wrap is registered. It is 1 for exactly the cycle after an edge where a count step wrapped, i.e. it is the registered value of tc when clr=0 and load=0. Otherwise wrap=0.
- Direction change mid-stream takes effect on the next edge; there is no pipeline to flush.
- Count values are never illegal after reset, clr or load, because digits stay < RADIX at all times.

Optional Feature:
- SATURATE_EN: when defined, the counter saturates instead of wrapping.
  - Counting up at all-(RADIX-1) holds; counting down at all-0 holds.
  - wrap is tied to 0. tc still asserts while at the limit, so it can act as a "stuck at limit" flag.
- When undefined: wrap-around behaviour as specified in Behaviour.

Test Plan (RADIX=3, NDIGITS=2, DW=2):
- Up-count wrap: rst pulse, then en=1, direct=1 for 9 clks. count steps 00,01,02,10,...,22 (base-3 digits), then 00. tc=1 while count=22. wrap=1 only in the cycle after the 00 transition.
- Down-count wrap: from count=00, en=1, direct=0 for 1 clk. count=22 and wrap=1 next cycle. A further step gives 21.
- Clear and load priority: clr=1, load=1, direct=0 in the same edge. count=22, wrap=0. Next, load=1 with load_val={2'd3,2'd1}. count={2,1} (clamped).
- Hold and mid-stream reversal: en=0 for 3 clks, count unchanged. Then toggle direct each clk from count=11 with en=1. Expect 12, 11, 12, 11.
- Async reset: assert rst between clock edges while count=21. count=00 and wrap=0 before the next edge; the counter stays at 00 while rst is high.
- SATURATE_EN build: up-count from 21 for 3 clks. Expect 22, 22, 22, with tc=1 and wrap=0 throughout.
